// File: rtl/pc_gen_bp_if.sv
// Execute-to-fetch resolution bus: the resolved control transfer travels toward
// the PC generator, and the flush/redirect response travels back.
interface pc_gen_bp_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [1:0]      ex_op;
    logic            ex_br;
    logic [XLEN-1:0] ex_offset;
    logic [XLEN-1:0] ex_c;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output ex_valid, ex_pc, ex_op, ex_br, ex_offset, ex_c,
               ex_pred_taken, ex_pred_target,
        input  flush, redirect_pc
    );

    modport slave (
        input  ex_valid, ex_pc, ex_op, ex_br, ex_offset, ex_c,
               ex_pred_taken, ex_pred_target,
        output flush, redirect_pc
    );
endinterface

// File: rtl/pc_gen_bp.sv
// Fetch PC register with a direct-mapped BTB (2-bit counters) for next-PC
// prediction; resolves execute-stage transfers and redirects on mispredicts.
module pc_gen_bp #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h0000_0000),
    parameter int              BTB_ENTRIES = 8,
    parameter int              CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc4,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    output logic [CNT_W-1:0] mispred_cnt,
    pc_gen_bp_if.slave       ex
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);
    localparam logic [XLEN-1:0] ONE  = XLEN'(1);

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_JALR   = 2'b01;
    localparam logic [1:0] OP_SEQ    = 2'b10;
    localparam logic [1:0] OP_JAL    = 2'b11;

    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
    logic [1:0]       btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]   f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    logic [IDX-1:0]   ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [XLEN-1:0]  ex_seq;
    logic [XLEN-1:0]  br_off;
    logic             act_taken;
    logic [XLEN-1:0]  act_target;
    logic             mispredict;
    logic [1:0]       ctr_next;

    assign f_idx       = pc[IDX+1:2];
    assign f_tag       = pc[XLEN-1:IDX+2];
    assign f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign pc4         = pc + FOUR;
    assign pred_taken  = f_hit && btb_ctr[f_idx][1];
    assign pred_target = pred_taken ? btb_target[f_idx] : pc4;

    assign ex_idx = ex.ex_pc[IDX+1:2];
    assign ex_tag = ex.ex_pc[XLEN-1:IDX+2];
    assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
    assign ex_seq = ex.ex_pc + FOUR;
    assign br_off = {{(XLEN-13){ex.ex_offset[12]}}, ex.ex_offset[12:0]};

    always_comb begin
        act_taken  = 1'b0;
        act_target = ex_seq;
        case (ex.ex_op)
            OP_JAL: begin
                act_taken  = 1'b1;
                act_target = ex.ex_pc + ex.ex_offset;
            end
            OP_JALR: begin
                act_taken  = 1'b1;
                act_target = ex.ex_c & ~ONE;
            end
            OP_BRANCH: begin
                act_taken  = ex.ex_br;
                act_target = ex.ex_pc + br_off;
            end
            default: begin
                act_taken  = 1'b0;
                act_target = ex_seq;
            end
        endcase
    end

    assign mispredict = ex.ex_valid &&
                        ((act_taken != ex.ex_pred_taken) ||
                         (act_taken && (act_target != ex.ex_pred_target)));

    // Flush is gated by reset so a stale execute bundle cannot escape during reset.
    assign ex.flush       = rst_n && mispredict;
    assign ex.redirect_pc = act_taken ? act_target : ex_seq;

    always_comb begin
        ctr_next = btb_ctr[ex_idx];
        if (ex.ex_br) begin
            if (btb_ctr[ex_idx] != 2'b11) ctr_next = btb_ctr[ex_idx] + 2'b01;
        end else begin
            if (btb_ctr[ex_idx] != 2'b00) ctr_next = btb_ctr[ex_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (ex.flush) begin
            pc <= ex.redirect_pc;
        end else if (!stall) begin
            pc <= pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_cnt <= '0;
        end else if (ex.flush && (mispred_cnt != {CNT_W{1'b1}})) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

    // Training happens on every resolved instruction, independent of stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (ex.ex_valid) begin
            case (ex.ex_op)
                OP_JAL, OP_JALR: begin
                    btb_valid[ex_idx]  <= 1'b1;
                    btb_tag[ex_idx]    <= ex_tag;
                    btb_target[ex_idx] <= act_target;
                    btb_ctr[ex_idx]    <= 2'b11;
                end
                OP_BRANCH: begin
                    if (ex_hit) begin
                        btb_ctr[ex_idx] <= ctr_next;
                        if (ex.ex_br) btb_target[ex_idx] <= act_target;
                    end else if (ex.ex_br) begin
                        btb_valid[ex_idx]  <= 1'b1;
                        btb_tag[ex_idx]    <= ex_tag;
                        btb_target[ex_idx] <= act_target;
                        btb_ctr[ex_idx]    <= 2'b10;
                    end
                end
                OP_SEQ: begin
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_gen_bp.sv
// Scoreboard bench for pc_gen_bp: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_gen_bp;
    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  mispred_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
        logic        fl;
        logic [31:0] rd;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    pc_gen_bp_if #(.XLEN(32)) exb ();

    pc_gen_bp #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .BTB_ENTRIES(8),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .pc(pc),
        .pc4(pc4),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .mispred_cnt(mispred_cnt),
        .ex(exb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareField(input string name, input string field,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField(e.name, "pc", pc, e.pc);
        compareField(e.name, "pc4", pc4, e.pc + 32'd4);
        compareField(e.name, "pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
        compareField(e.name, "pred_target", pred_target, e.ptg);
        compareField(e.name, "flush", {31'd0, exb.flush}, {31'd0, e.fl});
        compareField(e.name, "mispred_cnt", {30'd0, mispred_cnt}, {30'd0, e.cnt});
        if (e.fl) compareField(e.name, "redirect_pc", exb.redirect_pc, e.rd);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    task automatic applyStimulus(input string name, input logic stl,
                                 input logic v, input logic [31:0] epc,
                                 input logic [1:0] op, input logic br,
                                 input logic [31:0] off, input logic [31:0] c,
                                 input logic ptk, input logic [31:0] ptg,
                                 input logic [31:0] e_pc, input logic e_pt,
                                 input logic [31:0] e_ptg, input logic e_fl,
                                 input logic [31:0] e_rd, input logic [1:0] e_cnt);
        exp_t e;
        stall                = stl;
        exb.ex_valid         = v;
        exb.ex_pc            = epc;
        exb.ex_op            = op;
        exb.ex_br            = br;
        exb.ex_offset        = off;
        exb.ex_c             = c;
        exb.ex_pred_taken    = ptk;
        exb.ex_pred_target   = ptg;
        e.name = name; e.pc = e_pc; e.pt = e_pt; e.ptg = e_ptg;
        e.fl = e_fl; e.rd = e_rd; e.cnt = e_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input string name, input logic stl, input logic [31:0] e_pc,
                             input logic e_pt, input logic [31:0] e_ptg, input logic [1:0] e_cnt);
        applyStimulus(name, stl, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                      e_pc, e_pt, e_ptg, 1'b0, 32'h0, e_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        exb.ex_valid = 1'b0; exb.ex_pc = '0; exb.ex_op = 2'b10; exb.ex_br = 1'b0;
        exb.ex_offset = '0; exb.ex_c = '0; exb.ex_pred_taken = 1'b0; exb.ex_pred_target = '0;
        @(posedge clk);
        #1;

        // Mispredicting bundle while in reset must not flush.
        applyStimulus("rst_gate", 0, 1, 32'h40, 2'b11, 0, 32'h100, 0, 0, 0,
                      32'h0, 0, 32'h4, 0, 32'h0, 2'd0);
        rst_n = 1'b1;

        idleCycle("seq0", 0, 32'h0, 0, 32'h4, 2'd0);
        idleCycle("seq4", 0, 32'h4, 0, 32'h8, 2'd0);
        idleCycle("seq8", 0, 32'h8, 0, 32'hC, 2'd0);
        applyStimulus("br_alloc", 0, 1, 32'h10, 2'b00, 1, 32'h1FF8, 0, 0, 32'h14,
                      32'hC, 0, 32'h10, 1, 32'h8, 2'd0);
        idleCycle("after_flush", 0, 32'h8, 0, 32'hC, 2'd1);
        idleCycle("seq_c", 0, 32'hC, 0, 32'h10, 2'd1);
        applyStimulus("pred_hit", 0, 1, 32'h10, 2'b00, 0, 32'h1FF8, 0, 1, 32'h8,
                      32'h10, 1, 32'h8, 1, 32'h14, 2'd1);
        applyStimulus("ctr_dec2", 0, 1, 32'h10, 2'b00, 0, 32'h1FF8, 0, 0, 32'h0,
                      32'h14, 0, 32'h18, 0, 32'h0, 2'd2);
        applyStimulus("ctr_sat0", 0, 1, 32'h10, 2'b00, 0, 32'h1FF8, 0, 0, 32'h0,
                      32'h18, 0, 32'h1C, 0, 32'h0, 2'd2);
        applyStimulus("seq_mis", 0, 1, 32'hC, 2'b10, 0, 32'h0, 0, 1, 32'h10,
                      32'h1C, 0, 32'h20, 1, 32'h10, 2'd2);
        idleCycle("pred_nt", 0, 32'h10, 0, 32'h14, 2'd3);
        applyStimulus("jalr_ok", 0, 1, 32'h20, 2'b01, 0, 32'h0, 32'h1235, 1, 32'h1234,
                      32'h14, 0, 32'h18, 0, 32'h0, 2'd3);
        idleCycle("seq18", 0, 32'h18, 0, 32'h1C, 2'd3);
        idleCycle("seq1c", 0, 32'h1C, 0, 32'h20, 2'd3);
        idleCycle("jalr_pred", 0, 32'h20, 1, 32'h1234, 2'd3);
        applyStimulus("stall_flush", 1, 1, 32'h40, 2'b11, 0, 32'h100, 0, 0, 32'h0,
                      32'h1234, 0, 32'h1238, 1, 32'h140, 2'd3);
        idleCycle("stall_hold", 1, 32'h140, 0, 32'h144, 2'd3);
        idleCycle("stall_hold2", 1, 32'h140, 0, 32'h144, 2'd3);
        idleCycle("unstall", 0, 32'h140, 0, 32'h144, 2'd3);
        applyStimulus("wrap", 0, 1, 32'hFFFF_FFFC, 2'b11, 0, 32'h8, 0, 0, 32'h0,
                      32'h144, 0, 32'h148, 1, 32'h4, 2'd3);
        idleCycle("after_wrap", 0, 32'h4, 0, 32'h8, 2'd3);

        rst_n = 1'b0;
        applyStimulus("mid_rst", 0, 1, 32'h40, 2'b11, 0, 32'h100, 0, 0, 32'h0,
                      32'h0, 0, 32'h4, 0, 32'h0, 2'd0);
        rst_n = 1'b1;
        idleCycle("rst_seq0", 0, 32'h0, 0, 32'h4, 2'd0);
        applyStimulus("steer", 0, 1, 32'h3C, 2'b11, 0, 32'h4, 0, 0, 32'h0,
                      32'h4, 0, 32'h8, 1, 32'h40, 2'd0);
        idleCycle("btb_cleared", 0, 32'h40, 0, 32'h44, 2'd1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/pc_gen_bp.md
Name: pc_gen_bp

Overview:
- Fetch-stage PC generator for the pipelined core. Replaces the single-cycle combinational next-PC unit.
- Holds the architectural fetch PC in a register and predicts the next PC with a direct-mapped branch target buffer (BTB) that carries 2-bit saturating counters.
- Resolves control transfers reported by the execute stage. On a misprediction it redirects the PC and raises a flush.
- Keeps the existing op encoding: 11 = JAL, 01 = JALR, 10 = sequential, 00 = conditional branch.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BTB_ENTRIES, 8, number of BTB entries; power of two, ≥2. IDX = log2(BTB_ENTRIES).
- CNT_W, 16, width of the mispredict statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold the fetch PC. Does not block a redirect.
- pc  out  XLEN  current fetch PC (registered).
- pc4  out  XLEN  pc+4, combinational.
- pred_taken  out  1  BTB predicts taken for pc (combinational).
- pred_target  out  XLEN  predicted target; equals pc+4 when not predicted taken.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_pc  in  XLEN  PC of that instruction.
- ex_op  in  2  op code as above.
- ex_br  in  1  branch condition result (op 00 only).
- ex_offset  in  XLEN  immediate offset.
- ex_c  in  XLEN  JALR base+imm value.
- ex_pred_taken  in  1  prediction that travelled with the instruction.
- ex_pred_target  in  XLEN  predicted target that travelled with the instruction.
- flush  out  1  mispredict; kill the younger stages (combinational).
- redirect_pc  out  XLEN  corrected PC (valid when flush=1).
- mispred_cnt  out  CNT_W  saturating mispredict count.

Behaviour:
- Reset, asynchronous:
  - pc=RESET_PC.
  - All BTB entries valid=0, counter=2'b01.
  - mispred_cnt=0.
  - flush is forced to 0 while rst_n=0.
- BTB entry fields: valid, tag = pc[XLEN-1:IDX+2], target[XLEN-1:0], ctr[1:0]. Index = pc[IDX+1:2].
- Lookup (combinational on pc): hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = pred_taken ? target : pc+4.
- Actual outcome, computed from the ex_* inputs:
  - op 11: taken, target = ex_pc+ex_offset.
  - op 01: taken, target = ex_c with bit 0 cleared.
  - op 10: not taken.
  - op 00: taken = ex_br, target = ex_pc + sign-extend(ex_offset[12:0]).
  - All additions wrap modulo 2^XLEN.
- actual_next = taken ? target : ex_pc+4.
- Mispredict = ex_valid && (taken != ex_pred_taken || (taken && target != ex_pred_target)).
- flush = mispredict. redirect_pc = actual_next.
- PC update each rising edge, in priority order:
  1. flush: pc <= redirect_pc, regardless of stall.
  2. stall: pc holds.
  3. otherwise: pc <= pred_target.
- Latency: the redirected PC is visible on pc one cycle after flush.
- BTB update, on the edge when ex_valid=1 (independent of stall):
  - op 10: no update.
  - op 11/01: write valid=1, tag, target, ctr=2'b11.
  - op 00, entry hits on ex_pc: ctr is incremented if taken, decremented otherwise, saturating at 00 and 11. When taken, target is rewritten.
  - op 00, miss and taken: allocate (overwrite) with ctr=2'b10.
  - op 00, miss and not taken: no change.
- Same-cycle lookup and update of the same entry: the lookup sees the old contents. The write lands at the edge.
- mispred_cnt increments on each edge where flush=1 and holds at 2^CNT_W-1.
- Reset asserted mid-operation clears everything immediately. The first edge after release fetches from RESET_PC+4 unless stall=1.

Test Plan:
- Reset, no ex_valid, stall=0, RESET_PC=0 -> pc sequence 0, 4, 8, 12. pred_taken=0 throughout. flush=0.
- ex_valid, op 00, ex_pc=0x10, ex_br=1, ex_offset=0x1FF8 (-8), ex_pred_taken=0 -> flush=1, redirect_pc=0x08, next pc=0x08, mispred_cnt=1. Later fetch of 0x10 gives pred_taken=1 (ctr=10), pred_target=0x08.
- Same branch resolved not taken twice after allocation -> ctr goes 10→01→00. Prediction at 0x10 becomes not taken after the first decrement. A saturated ctr=00 stays 00.
- op 01, ex_c=0x0000_1235, ex_pred_taken=1, ex_pred_target=0x1234 -> target 0x1234, no flush. The BTB entry is refreshed with ctr=11.
- stall=1 together with a mispredict (op 11, ex_pc=0x40, offset=0x100) -> pc=0x140 on the next edge despite stall. Then stall holds pc at 0x140.
- Wrap-around and saturation, CNT_W=2:
  - op 11 at ex_pc=0xFFFF_FFFC, offset=8 -> target 0x0000_0004.
  - Four mispredicts -> mispred_cnt=3 and holds.
  - Reset mid-stream -> pc=RESET_PC and all predictions not taken.
